// File: rtl/tt_spi_pkg.sv
// Shared types and constants for the TT SPI RAM controller.
package tt_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int PIN_CS_N = 0;
  localparam int PIN_MOSI = 1;
  localparam int PIN_MISO = 2;
  localparam int PIN_SCLK = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'h0B;

endpackage

// File: rtl/tt_spi_clkgen.sv
// SCLK generator: HALF_DIV clk cycles per SCLK half-period while run is high.
// rise_tick/fall_tick flag the clk edge on which SCLK will go 0->1 / 1->0.
module tt_spi_clkgen #(
  parameter int HALF_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam logic [3:0] DIV_LAST = 4'(HALF_DIV - 1);

  logic [3:0] div_q, div_d;
  logic       sclk_q, sclk_d;
  logic       phase_end;

  assign phase_end = run && (div_q == DIV_LAST);
  assign rise_tick = phase_end && !sclk_q;
  assign fall_tick = phase_end && sclk_q;
  assign sclk      = sclk_q;

  // Divider advance and SCLK toggle at the end of each half-period.
  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clear || !run) begin
      div_d  = 4'd0;
      sclk_d = 1'b0;
    end else if (phase_end) begin
      div_d  = 4'd0;
      sclk_d = !sclk_q;
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  // Divider and SCLK phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 4'd0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/tt_spi_ram_ctrl.sv
// Single-byte SPI RAM controller (mode 0) driving the TT uio pins.
// One frame = {cmd, addr, data}, MSB first; read byte is the last 8 MISO samples.
module tt_spi_ram_ctrl
  import tt_spi_pkg::*;
#(
  parameter int HALF_DIV  = 1,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 busy,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam int         N        = 16 + ADDR_BITS;
  localparam logic [5:0] LAST_BIT = 6'(N - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   shift_q, shift_d;
  logic [5:0]     bit_q, bit_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     rdata_q, rdata_d;
  logic           wr_q, wr_d;
  logic           accept, last_fall;
  logic           sclk, rise_tick, fall_tick;
  logic           unused_uio_in;

  // Only MISO is used from the pad inputs.
  assign unused_uio_in = ^{uio_in[7:3], uio_in[1:0]};

  assign req_ready = (state_q == IDLE) && ena && !rst;
  assign accept    = req_valid && req_ready;
  assign last_fall = fall_tick && (bit_q == 6'd0);

  tt_spi_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
    .clk       (clk),
    .rst       (rst),
    .run       (state_q == SHIFT),
    .clear     (accept),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // State register plus frame datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= 6'd0;
      rx_q    <= 8'h00;
      rdata_q <= 8'h00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
    end
  end

  // Next-state: the frame ends on the falling edge after the last bit's high phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame capture, MOSI shift on SCLK fall, MISO sample on SCLK rise.
  always_comb begin
    shift_d = shift_q;
    bit_d   = bit_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    if (accept) begin
      wr_d    = req_write;
      shift_d = {(req_write ? CMD_WRITE : CMD_READ), req_addr, req_wdata};
      bit_d   = LAST_BIT;
      rx_d    = 8'h00;
    end else if (state_q == SHIFT) begin
      if (rise_tick) begin
        rx_d = {rx_q[6:0], uio_in[PIN_MISO]};
      end
      if (fall_tick) begin
        shift_d = {shift_q[N-2:0], 1'b0};
        if (bit_q != 6'd0) begin
          bit_d = bit_q - 6'd1;
        end
      end
      if (last_fall) begin
        rdata_d = wr_q ? 8'h00 : rx_q;
      end
    end
  end

  // Pin and status outputs decoded from the current state.
  always_comb begin
    uio_out           = 8'h00;
    uio_out[PIN_CS_N] = (state_q != SHIFT);
    uio_out[PIN_MOSI] = (state_q == SHIFT) && shift_q[N-1];
    uio_out[PIN_SCLK] = sclk;
    rsp_valid         = (state_q == DONE);
    busy              = (state_q != IDLE);
  end

  assign uio_oe    = UIO_OE_MASK;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_tt_spi_ram_ctrl.sv
// Bench for tt_spi_ram_ctrl: two instances (defaults, and HALF_DIV=3/ADDR_BITS=16),
// each with a pin-level SPI RAM model and a scoreboard fed at request acceptance.
`timescale 1ns/1ps
module tb_tt_spi_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic        rst  [2];
  logic        ena  [2];
  logic        vld  [2];
  logic        wr   [2];
  logic [23:0] addr [2];
  logic [7:0]  wd   [2];
  logic        rdy  [2];
  logic        rspv [2];
  logic        bsy  [2];
  logic [7:0]  rdat [2];
  logic [7:0]  uout [2];
  logic [7:0]  uoe  [2];

  typedef struct {
    int          rsp_cyc;
    logic [7:0]  rdata;
    logic [63:0] frame;
    bit          w;
    int          a;
    logic [7:0]  wdat;
  } exp_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Initial RAM contents for never-written addresses.
  function automatic logic [7:0] dflt(input logic [23:0] a);
    return (a == 24'h00FFEE) ? 8'h3C : (a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int HD = (g == 0) ? 1 : 3;
    localparam int AB = (g == 0) ? 24 : 16;
    localparam int N  = 16 + AB;

    logic [7:0] uin;

    tt_spi_ram_ctrl #(.HALF_DIV(HD), .ADDR_BITS(AB)) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .ena       (ena[g]),
      .req_valid (vld[g]),
      .req_ready (rdy[g]),
      .req_write (wr[g]),
      .req_addr  (addr[g][AB-1:0]),
      .req_wdata (wd[g]),
      .rsp_valid (rspv[g]),
      .rsp_rdata (rdat[g]),
      .busy      (bsy[g]),
      .uio_in    (uin),
      .uio_out   (uout[g]),
      .uio_oe    (uoe[g])
    );

    exp_t        q[$];
    logic [7:0]  ref_mem[int];
    logic [7:0]  ram_mem[int];
    int          acc_c = -100000;
    logic [63:0] frame = '0, done_frame = '0;
    int          nbits = 0, lowcnt = 0, last_rise = 0, done_bits = 0, done_low = 0;
    int          cap_cmd = 0, cap_addr = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    logic [7:0]  last_rd = 8'h00;

    always @(negedge clk) begin : mon
      logic cs, sc, mo, busy_exp, cs_exp;
      logic [7:0] rb;
      exp_t e;
      int ak;
      cs = uout[g][0];
      sc = uout[g][3];
      mo = uout[g][1];
      uin = 8'($urandom);
      if (rst[g]) begin
        chk("rst_uio_out", 64'(uout[g]), 64'h01);
        chk("rst_uio_oe", 64'(uoe[g]), 64'h0B);
        chk("rst_req_ready", 64'(rdy[g]), 64'd0);
        chk("rst_rsp_valid", 64'(rspv[g]), 64'd0);
        chk("rst_busy", 64'(bsy[g]), 64'd0);
        chk("rst_rsp_rdata", 64'(rdat[g]), 64'd0);
        q.delete();
        acc_c = -100000;
        nbits = 0; lowcnt = 0; cap_cmd = 0;
        last_rd = 8'h00;
        p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
      end else begin
        // SPI RAM pin model
        if (!cs) begin
          if (p_cs) begin
            nbits = 0; lowcnt = 0; frame = '0; cap_cmd = 0; cap_addr = 0;
          end
          lowcnt++;
          if (!p_cs && mo != p_mosi)
            chk("mosi_changes_on_sclk_fall", 64'({p_sclk, sc}), 64'b10);
          if (sc && !p_sclk) begin
            frame = {frame[62:0], mo};
            nbits++;
            if (nbits == 1) chk("first_sclk_rise", 64'(cyc - acc_c), 64'(HD + 1));
            else            chk("sclk_period", 64'(cyc - last_rise), 64'(2 * HD));
            last_rise = cyc;
            if (nbits == 8 + AB) begin
              cap_cmd  = int'(frame[AB+7:AB]);
              cap_addr = int'(frame[AB-1:0]);
            end
          end
          if (cap_cmd == 8'h03 && nbits >= 8 + AB && nbits < N) begin
            rb = ram_mem.exists(cap_addr) ? ram_mem[cap_addr] : dflt(24'(cap_addr));
            uin[2] = rb[7 - (nbits - 8 - AB)];
          end
        end else if (!p_cs) begin
          done_frame = frame; done_bits = nbits; done_low = lowcnt;
          if (nbits == N && cap_cmd == 8'h02) ram_mem[cap_addr] = frame[7:0];
        end

        // Reference timing derived from the last acceptance
        busy_exp = (cyc >= acc_c + 1) && (cyc <= acc_c + 2 * HD * N + 1);
        cs_exp   = !((cyc >= acc_c + 1) && (cyc <= acc_c + 2 * HD * N));
        chk("uio_oe", 64'(uoe[g]), 64'h0B);
        chk("uio_out_unused_bits", 64'(uout[g] & 8'hF4), 64'd0);
        chk("busy", 64'(bsy[g]), 64'(busy_exp));
        chk("req_ready", 64'(rdy[g]), 64'(ena[g] && !busy_exp));
        chk("cs_n", 64'(cs), 64'(cs_exp));

        // Scoreboard
        if (rspv[g]) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp_valid", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_cycle", 64'(cyc), 64'(e.rsp_cyc));
            chk("rsp_rdata", 64'(rdat[g]), 64'(e.rdata));
            chk("done_pins", 64'(uout[g][3:0]), 64'b0001);
            chk("frame_bits", 64'(done_bits), 64'(N));
            chk("cs_low_cycles", 64'(done_low), 64'(2 * HD * N));
            if (e.w) begin
              chk("frame_write", done_frame, e.frame);
              ref_mem[e.a] = e.wdat;
            end else begin
              chk("frame_read_cmd_addr", done_frame >> 8, e.frame >> 8);
            end
          end
          last_rd = rdat[g];
        end else begin
          chk("rsp_rdata_hold", 64'(rdat[g]), 64'(last_rd));
          if (q.size() != 0 && cyc > q[0].rsp_cyc) begin
            chk("rsp_missing", 64'(cyc), 64'(q[0].rsp_cyc));
            void'(q.pop_front());
          end
        end

        // Acceptance: push the expected response
        if (vld[g] && rdy[g]) begin
          ak        = int'(addr[g][AB-1:0]);
          e.w       = wr[g];
          e.a       = ak;
          e.wdat    = wd[g];
          e.rsp_cyc = cyc + 2 * HD * N + 1;
          e.frame   = (64'(wr[g] ? 8'h02 : 8'h03) << (AB + 8)) |
                      (64'(addr[g][AB-1:0]) << 8) | 64'(wd[g]);
          if (wr[g]) e.rdata = 8'h00;
          else       e.rdata = ref_mem.exists(ak) ? ref_mem[ak] : dflt(24'(ak));
          q.push_back(e);
          acc_c = cyc;
        end
        p_cs = cs; p_sclk = sc; p_mosi = mo;
      end
    end
  end

  task automatic wait_ready(input int g, output int ac);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[g] && n < 4000);
    if (!rdy[g]) chk("accept_timeout", 64'(rdy[g]), 64'd1);
    ac = cyc;
  endtask

  task automatic do_req(input int g, input logic w, input logic [23:0] a,
                        input logic [7:0] d, output int ac);
    @(posedge clk); #1;
    vld[g] = 1'b1; wr[g] = w; addr[g] = a; wd[g] = d;
    wait_ready(g, ac);
    @(posedge clk); #1;
    vld[g] = 1'b0; wr[g] = 1'($urandom); addr[g] = 24'($urandom); wd[g] = 8'($urandom);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(posedge clk); #1;
    do begin
      @(negedge clk);
      n++;
    end while (bsy[g] && n < 4000);
    if (bsy[g]) chk("idle_timeout", 64'(bsy[g]), 64'd0);
  endtask

  function automatic logic [23:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 24'h012345;
      1:       return 24'h00FFEE;
      2:       return 24'($urandom_range(0, 3));
      default: return 24'($urandom);
    endcase
  endfunction

  initial begin
    int a0, a1;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; ena[i] = 1'b0; vld[i] = 1'b0;
      wr[i] = 1'b0; addr[i] = 24'h0; wd[i] = 8'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; ena[0] = 1'b1;

    // Directed write and read at default parameters
    do_req(0, 1'b1, 24'h012345, 8'hA5, a0);
    wait_idle(0);
    do_req(0, 1'b0, 24'h00FFEE, 8'($urandom), a0);
    wait_idle(0);

    // Back-to-back with req_valid held high
    @(posedge clk); #1;
    vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 24'h000100; wd[0] = 8'h11;
    wait_ready(0, a0);
    @(posedge clk); #1 addr[0] = 24'h000101; wd[0] = 8'h22;
    wait_ready(0, a1);
    chk("b2b_second_accept", 64'(a1 - a0), 64'd82);
    @(posedge clk); #1 vld[0] = 1'b0;
    wait_idle(0);

    // ena dropped mid-transfer blocks only the next accept
    @(posedge clk); #1;
    vld[0] = 1'b1; wr[0] = 1'b1; addr[0] = 24'h000200; wd[0] = 8'h33;
    wait_ready(0, a0);
    @(posedge clk); #1 addr[0] = 24'h000201; wd[0] = 8'h44;
    while (cyc < a0 + 40) begin @(posedge clk); #1; end
    ena[0] = 1'b0;
    repeat (70) @(posedge clk);
    #1 ena[0] = 1'b1;
    wait_ready(0, a1);
    chk("ena_release_accept", 64'(a1 - a0), 64'd110);
    @(posedge clk); #1 vld[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of a read, then a clean read
    do_req(0, 1'b0, 24'h000201, 8'h00, a0);
    while (cyc < a0 + 30) begin @(posedge clk); #1; end
    rst[0] = 1'b1;
    #1;
    chk("abort_cs_n_high", 64'(uout[0][0]), 64'd1);
    chk("abort_busy_low", 64'(bsy[0]), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;
    do_req(0, 1'b0, 24'h012345, 8'h00, a0);
    wait_idle(0);

    // Random traffic at default parameters
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_req(0, 1'($urandom), pick_addr(), 8'($urandom), a0);
    end
    wait_idle(0);

    // HALF_DIV=3, ADDR_BITS=16 instance
    @(posedge clk); #1 rst[1] = 1'b0; ena[1] = 1'b1;
    do_req(1, 1'b0, 24'h00FFEE, 8'($urandom), a0);
    wait_idle(1);
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_req(1, 1'($urandom), pick_addr(), 8'($urandom), a0);
    end
    wait_idle(1);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
